// File: rtl/addsub_sched.sv
// addsub_sched: round-robin scheduler sharing one 16-bit add/sub datapath among NREQ requesters.
// Define ADDSUB_SCHED_STATS_EN to enable the stat_ops_o / stat_tmo_o counters (tied to zero otherwise).
module addsub_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ-1:0]      req_sub_i,
    input  logic [NREQ*32-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 dp_valid_o,
    output logic                 dp_nadd_sub_o,
    output logic [31:0]          dp_wdata_o,
    input  logic                 dp_ready_i,
    input  logic [31:0]          dp_rdata_i,
    output logic                 dp_reset_o,
    output logic                 busy_o,
    output logic [15:0]          stat_ops_o,
    output logic [15:0]          stat_tmo_o
);

    localparam int SW = IDW + 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam int unsigned NR = NREQ;

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic            any_req;
    logic [CW-1:0]   wd_cnt;
    logic            exec_ok;
    logic            exec_tmo;

    // Scan upward from rr_ptr with wrap; the sum needs one extra bit before folding back.
    always_comb begin
        logic [SW-1:0]  sum;
        logic [IDW-1:0] cand;
        any_req  = 1'b0;
        grant_id = '0;
        sum      = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!any_req && req_valid_i[cand]) begin
                any_req  = 1'b1;
                grant_id = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && any_req) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    assign exec_ok  = (state == EXEC) && dp_ready_i;
    assign exec_tmo = (state == EXEC) && !dp_ready_i && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            dp_nadd_sub_o <= 1'b0;
            dp_wdata_o    <= '0;
            rsp_id_o      <= '0;
            rsp_data_o    <= '0;
            rsp_err_o     <= 1'b0;
            rsp_valid_o   <= 1'b0;
            dp_valid_o    <= 1'b0;
            busy_o        <= 1'b0;
            dp_reset_o    <= 1'b1;
            wd_cnt        <= '0;
        end else begin
            dp_reset_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        dp_wdata_o    <= req_data_i[{grant_id, 5'd0} +: 32];
                        dp_nadd_sub_o <= req_sub_i[grant_id];
                        rsp_id_o      <= grant_id;
                        busy_o        <= 1'b1;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    dp_valid_o <= 1'b1;
                    wd_cnt     <= '0;
                    state      <= EXEC;
                end
                EXEC: begin
                    if (exec_ok) begin
                        rsp_data_o  <= dp_rdata_i;
                        rsp_err_o   <= 1'b0;
                        dp_valid_o  <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else if (exec_tmo) begin
                        rsp_data_o  <= '0;
                        rsp_err_o   <= 1'b1;
                        dp_reset_o  <= 1'b1;
                        dp_valid_o  <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        rr_ptr      <= (rsp_id_o == IDW'(NREQ - 1)) ? '0 : rsp_id_o + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDSUB_SCHED_STATS_EN
    logic [15:0] ops_cnt;
    logic [15:0] tmo_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ops_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (exec_ok) begin
                ops_cnt <= ops_cnt + 1'b1;
            end
            if (exec_tmo) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign stat_ops_o = ops_cnt;
    assign stat_tmo_o = tmo_cnt;
`else
    assign stat_ops_o = '0;
    assign stat_tmo_o = '0;
`endif

endmodule

// File: tb/tb_addsub_sched.sv
// tb_addsub_sched: randomized self-checking bench for addsub_sched against a transaction-level model.
// Stat port expectations follow ADDSUB_SCHED_STATS_EN.
module tb_addsub_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                wb_rst_n_i;
    logic [NREQ-1:0]     req_valid_i;
    logic [NREQ-1:0]     req_sub_i;
    logic [NREQ*32-1:0]  req_data_i;
    logic [NREQ-1:0]     req_ready_o;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [IDW-1:0]      rsp_id_o;
    logic [31:0]         rsp_data_o;
    logic                rsp_err_o;
    logic                dp_valid_o;
    logic                dp_nadd_sub_o;
    logic [31:0]         dp_wdata_o;
    logic                dp_ready_i;
    logic [31:0]         dp_rdata_i;
    logic                dp_reset_o;
    logic                busy_o;
    logic [15:0]         stat_ops_o;
    logic [15:0]         stat_tmo_o;

    addsub_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (wb_rst_n_i),
        .req_valid_i   (req_valid_i),
        .req_sub_i     (req_sub_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_id_o      (rsp_id_o),
        .rsp_data_o    (rsp_data_o),
        .rsp_err_o     (rsp_err_o),
        .dp_valid_o    (dp_valid_o),
        .dp_nadd_sub_o (dp_nadd_sub_o),
        .dp_wdata_o    (dp_wdata_o),
        .dp_ready_i    (dp_ready_i),
        .dp_rdata_i    (dp_rdata_i),
        .dp_reset_o    (dp_reset_o),
        .busy_o        (busy_o),
        .stat_ops_o    (stat_ops_o),
        .stat_tmo_o    (stat_tmo_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int               model_ptr = 0;
    int               model_ops = 0;
    int               model_tmo = 0;
    logic [31:0]      op_data [NREQ];
    logic [NREQ-1:0]  op_sub;

    // Datapath behaviour knobs
    int ack_delay = 1;
    bit dp_hang   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (model_ptr + k) % NREQ;
            if (mask[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] data, input logic sub);
        logic [31:0] x;
        logic [31:0] y;
        x = {16'h0000, data[31:16]};
        y = {16'h0000, data[15:0]};
        return sub ? x - y : x + y;
    endfunction

    task automatic check_stats(input string tag);
`ifdef ADDSUB_SCHED_STATS_EN
        check({tag, "_stat_ops"}, 32'(stat_ops_o), 32'(model_ops[15:0]));
        check({tag, "_stat_tmo"}, 32'(stat_tmo_o), 32'(model_tmo[15:0]));
`else
        check({tag, "_stat_ops"}, 32'(stat_ops_o), 32'(0));
        check({tag, "_stat_tmo"}, 32'(stat_tmo_o), 32'(0));
`endif
    endtask

    task automatic drive_reqs(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            req_data_i[32*k +: 32] = op_data[k];
        end
        req_sub_i   = op_sub;
        req_valid_i = mask;
    endtask

    // Datapath stand-in: acknowledges ack_delay cycles after dp_valid_o rises, computing from its own inputs.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        dp_ready_i = 1'b0;
        dp_rdata_i = '0;
        forever begin
            @(negedge clk);
            dp_ready_i = 1'b0;
            if (dp_valid_o) begin
                if (!dp_hang && wait_cnt == ack_delay) begin
                    dp_ready_i = 1'b1;
                    dp_rdata_i = dp_nadd_sub_o
                        ? ({16'h0000, dp_wdata_o[31:16]} - {16'h0000, dp_wdata_o[15:0]})
                        : ({16'h0000, dp_wdata_o[31:16]} + {16'h0000, dp_wdata_o[15:0]});
                end
                wait_cnt++;
            end else begin
                wait_cnt   = 0;
                dp_rdata_i = $urandom;
            end
        end
    end

    // Entered and left at the negedge of an IDLE cycle.
    task automatic do_op(input logic [NREQ-1:0] mask, input int delay, input int stall, input bit hang);
        int          g;
        int          exec_n;
        int          rst_pulses;
        logic [31:0] exp;
        ack_delay = delay;
        dp_hang   = hang;
        drive_reqs(mask);
        #1;
        g   = model_grant(mask);
        exp = hang ? 32'h0 : model_result(op_data[g], op_sub[g]);
        check("accept_onehot", 32'(req_ready_o), 32'(1) << g);
        check("idle_busy", 32'(busy_o), 32'(0));
        @(posedge clk); @(negedge clk);
        rst_pulses = 0;
        check("setup_dp_valid", 32'(dp_valid_o), 32'(0));
        check("setup_wdata", dp_wdata_o, op_data[g]);
        check("setup_op", 32'(dp_nadd_sub_o), 32'(op_sub[g]));
        check("setup_busy", 32'(busy_o), 32'(1));
        req_valid_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_data_i[32*k +: 32] = $urandom;
        end
        req_sub_i = NREQ'($urandom);
        @(posedge clk); @(negedge clk);
        check("exec_dp_valid", 32'(dp_valid_o), 32'(1));
        check("exec_wdata", dp_wdata_o, op_data[g]);
        exec_n = 0;
        while (!rsp_valid_o && exec_n < 40) begin
            exec_n++;
            if (dp_reset_o) rst_pulses++;
            @(posedge clk); @(negedge clk);
        end
        check("exec_cycles", 32'(exec_n), hang ? 32'(TIMEOUT) : 32'(delay + 1));
        check("rsp_id", 32'(rsp_id_o), 32'(g));
        check("rsp_data", rsp_data_o, exp);
        check("rsp_err", 32'(rsp_err_o), 32'(hang));
        check("rsp_dp_valid", 32'(dp_valid_o), 32'(0));
        if (dp_reset_o) rst_pulses++;
        for (int s = 0; s < stall; s++) begin
            req_valid_i = mask;
            #1;
            check("bp_req_ready", 32'(req_ready_o), 32'(0));
            @(posedge clk); @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid_o), 32'(1));
            check("bp_rsp_id", 32'(rsp_id_o), 32'(g));
            check("bp_rsp_data", rsp_data_o, exp);
            check("bp_rsp_err", 32'(rsp_err_o), 32'(hang));
            check("bp_dp_valid", 32'(dp_valid_o), 32'(0));
            if (dp_reset_o) rst_pulses++;
        end
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready_i = 1'b0;
        if (dp_reset_o) rst_pulses++;
        check("release_idle", {30'h0, rsp_valid_o, busy_o}, 32'(0));
        check("dp_reset_pulses", 32'(rst_pulses), 32'(hang ? 1 : 0));
        model_ptr = (g + 1) % NREQ;
        if (hang) model_tmo++;
        else      model_ops++;
        check_stats("op");
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wb_rst_n_i  = 1'b0;
        req_valid_i = '0;
        req_sub_i   = '0;
        req_data_i  = '0;
        rsp_ready_i = 1'b0;
        for (int k = 0; k < NREQ; k++) op_data[k] = $urandom;
        op_sub = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        check("rst_dp_valid", 32'(dp_valid_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_dp_reset", 32'(dp_reset_o), 32'(1));
        check("rst_rsp_data", rsp_data_o, 32'(0));
        check("rst_rsp_id", 32'(rsp_id_o), 32'(0));
        check("rst_rsp_err", 32'(rsp_err_o), 32'(0));
        check_stats("rst");
        wb_rst_n_i = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_release_dp_reset", 32'(dp_reset_o), 32'(0));

        // Fairness: every requester held valid, back-to-back responses
        for (int r = 0; r < 6; r++) begin
            do_op(4'b1111, 0, 0, 1'b0);
        end

        op_data[0] = 32'h0003_0005; op_sub[0] = 1'b0;
        do_op(4'b0001, 1, 0, 1'b0);
        op_data[2] = 32'h0003_0005; op_sub[2] = 1'b1;
        do_op(4'b0100, 1, 0, 1'b0);
        op_data[3] = 32'hFFFF_FFFF; op_sub[3] = 1'b0;
        do_op(4'b1000, 2, 0, 1'b0);
        op_data[1] = 32'h0000_FFFF; op_sub[1] = 1'b1;
        do_op(4'b1010, 2, 10, 1'b0);

        // Watchdog abort followed by a normal op
        do_op(4'b0001, 0, 2, 1'b1);
        op_data[0] = 32'h1234_0F0F; op_sub[0] = 1'b0;
        do_op(4'b0001, 1, 0, 1'b0);

        // Reset while in EXEC; rr pointer is 1 beforehand
        op_data[2] = 32'h00AA_0055; op_sub[2] = 1'b0;
        dp_hang = 1'b1;
        drive_reqs(4'b0100);
        @(posedge clk); @(negedge clk);
        req_valid_i = '0;
        @(posedge clk); @(negedge clk);
        check("pre_rst_exec", 32'(dp_valid_o), 32'(1));
        wb_rst_n_i = 1'b0;
        @(posedge clk); @(negedge clk);
        wb_rst_n_i = 1'b1;
        check("midrst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        check("midrst_dp_valid", 32'(dp_valid_o), 32'(0));
        check("midrst_busy", 32'(busy_o), 32'(0));
        check("midrst_dp_reset", 32'(dp_reset_o), 32'(1));
        @(posedge clk); @(negedge clk);
        check("postrst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        check("postrst_dp_reset", 32'(dp_reset_o), 32'(0));
        model_ptr = 0;
        model_ops = 0;
        model_tmo = 0;
        check_stats("postrst");
        do_op(4'b1111, 0, 0, 1'b0);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            logic [NREQ-1:0] mask;
            for (int k = 0; k < NREQ; k++) op_data[k] = $urandom;
            op_sub = NREQ'($urandom);
            mask   = NREQ'($urandom_range(1, 15));
            do_op(mask, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
